// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int baud_cnt_w(input int cpb);
        return (cpb > 2) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO for the UART receiver; storage is not reset, pointers are.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign dout  = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with show-ahead FIFO and sticky error flags.
// Define UART_RX_PARITY_EN for an even-parity bit and the o_parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10000000,
    parameter int BAUD_RATE   = 1000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_uart_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_frame_err,
    output logic                          o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          o_parity_err,
`endif
    input  logic                          i_err_clr
);

    localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW  = baud_cnt_w(CPB);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

    logic          sync_p0, sync_p1, rx_p2;
    logic [1:0]    flush_cnt;
    logic          fall;
    rx_state_t     state, state_n;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          cnt_clr, shift_en, push, frame_set;
    logic          fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic          par_set, par_bad;
`endif

    // Stage p0/p1: metastability synchronizer; p2: previous sample for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            rx_p2     <= 1'b1;
            flush_cnt <= '0;
        end else begin
            sync_p0 <= i_uart_rx;
            sync_p1 <= sync_p0;
            rx_p2   <= sync_p1;
            if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Edges are ignored until the reset value has flushed out of the synchronizer.
    assign fall = rx_p2 & ~sync_p1 & (flush_cnt == 2'd3);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        case (state)
            ST_IDLE: if (fall) state_n = ST_START;
            ST_START: if (baud_cnt == HALF_M1) begin
                cnt_clr = 1'b1;
                state_n = sync_p1 ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (baud_cnt == FULL_M1) begin
                cnt_clr  = 1'b1;
                shift_en = 1'b1;
                if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_n = ST_PARITY;
`else
                    state_n = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (baud_cnt == FULL_M1) begin
                cnt_clr = 1'b1;
                par_set = (sync_p1 != ^shreg);
                state_n = ST_STOP;
            end
`endif
            ST_STOP: if (baud_cnt == FULL_M1) begin
                cnt_clr = 1'b1;
                state_n = ST_IDLE;
                if (sync_p1) begin
`ifdef UART_RX_PARITY_EN
                    push = ~par_bad;
`else
                    push = 1'b1;
`endif
                end else begin
                    frame_set = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            baud_cnt <= (cnt_clr || state == ST_IDLE) ? '0 : baud_cnt + 1'b1;
            if (state == ST_IDLE) bit_cnt <= '0;
            else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {sync_p1, shreg[7:1]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= (o_frame_err & ~i_err_clr) | frame_set;
            o_overrun   <= (o_overrun & ~i_err_clr) | (push & fifo_full & ~(i_ready & o_valid));
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            par_bad      <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            if (state == ST_IDLE) par_bad <= 1'b0;
            else if (par_set)     par_bad <= 1'b1;
            o_parity_err <= (o_parity_err & ~i_err_clr) | par_set;
        end
    end
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (shreg),
        .pop    (i_ready),
        .dout   (o_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (o_level)
    );

    assign o_valid = ~fifo_empty;

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-oriented UART receiver: the receive end of the 8N1 serial link the SOC already drives on its transmit pin. It oversamples the RX pin with the system clock, recovers bytes, and queues them in a small show-ahead FIFO. The CPU reads the FIFO through a valid/ready handshake via the IO page, next to the existing transmitter. Sticky error flags report framing errors and overruns.

## Interface
Parameters:
- CLK_FREQ_HZ, 10000000, system clock frequency
- BAUD_RATE, 1000000, line bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer, ≥ 4)
- FIFO_DEPTH, 4, receive FIFO entries (power of 2, ≥ 2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- i_uart_rx  in  1  serial input, idle high, asynchronous to clk
- o_data  out  8  head-of-FIFO byte, meaningful only while o_valid=1
- o_valid  out  1  FIFO non-empty
- i_ready  in  1  consumer pops the head on a cycle where o_valid & i_ready
- o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- o_frame_err  out  1  sticky: a frame had stop bit = 0
- o_overrun  out  1  sticky: a good byte was dropped because the FIFO was full
- i_err_clr  in  1  single-cycle pulse clears both sticky flags

## Operation
- i_uart_rx passes through a 2-FF synchronizer; both flops reset to 1.
- Receiver FSM states and transitions:
  - IDLE → START on synchronized 1→0.
  - START waits CLKS_PER_BIT/2 cycles, then samples. A 0 → DATA; a 1 → IDLE (glitch, nothing recorded).
  - DATA takes 8 samples at CLKS_PER_BIT spacing, LSB first, into a shift register.
  - DATA → STOP after the 8th sample (→ PARITY first when parity is enabled).
  - STOP samples once after CLKS_PER_BIT. A 1 pushes the byte; a 0 sets o_frame_err and discards the byte. Either way → IDLE on the same cycle.
- Push on a full FIFO: the byte is dropped and o_overrun is set. If a pop happens on the same cycle, the push succeeds and no overrun is flagged.
- Simultaneous push and pop on a non-empty FIFO: o_level unchanged.
- i_err_clr coinciding with a new error: the error wins, and the flag stays 1.
- Pointers wrap modulo FIFO_DEPTH. o_level saturates at FIFO_DEPTH by construction, never wraps.
- A new start bit is accepted immediately after a STOP sample (back-to-back frames).

## Timing
- Reset values:
  - o_valid=0, o_level=0, o_frame_err=0, o_overrun=0, o_data=8'h00.
  - FSM=IDLE, bit counter=0, baud counter=0.
- Reset asserted mid-frame aborts the frame. The partial byte is never pushed. After release, reception restarts only on the next falling edge.
- Latency:
  - The synchronized edge lags the pin by 2 cycles.
  - The stop sample occurs 9.5·CLKS_PER_BIT cycles after the synchronized edge (10.5 with parity).
  - The byte is written on the stop-sample cycle; o_valid and o_level update the following cycle.
- o_data is combinational from the FIFO head (show-ahead). It is stable while o_valid=1 and no pop occurs.
- A pop takes effect at the clock edge. The next entry (or o_valid=0) is visible the cycle after.

## Configuration
- UART_RX_PARITY_EN defined:
  - A PARITY state follows DATA and samples one even-parity bit.
  - Mismatch sets sticky o_parity_err (extra 1-bit output, reset 0, cleared by i_err_clr) and discards the byte.
  - Frame length is 11 bits.
- Undefined:
  - No PARITY state and no o_parity_err port; 8N1 only.

## Structure
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - A function computing CLKS_PER_BIT and baud counter width.
- One sub-module, uart_rx_fifo:
  - Parameterized depth, 8-bit width.
  - push/pop/full/empty/level ports.
  - Register-array storage with async reset on pointers only.
- The top holds the synchronizer, FSM, baud and bit counters, and error flags.

## Test plan
- Defaults, send 0x55 as 8N1 frame, i_ready=1 → o_valid pulses one cycle with o_data=0x55; flags stay 0.
- Low glitch of 3 cycles on i_uart_rx → FSM returns to IDLE; o_valid and o_level stay 0.
- 0xA3 sent with stop bit 0 → o_frame_err=1, o_level=0. i_err_clr pulse → o_frame_err=0.
- i_ready=0, send 0x01..0x05 back-to-back → o_level=4, o_overrun=1. Pops return 0x01..0x04 in order; 0x05 is absent.
- Pop on the same cycle the 5th byte's stop sample lands (FIFO full) → o_overrun stays 0, o_level stays 4.
- resetn pulsed low mid-data of 0x3C, then 0x7E sent → only 0x7E received. With UART_RX_PARITY_EN, 0x07 sent with parity bit 0 → o_parity_err=1, no push.
